// File: rtl/led_matrix_rx_pkg.sv
// Shared types and helpers for the LED matrix row-driver link receiver.
// Holds the FSM state encoding, default geometry and the one-hot column encoder.
package led_matrix_rx_pkg;

    localparam int LED_COL_N   = 16;
    localparam int LED_ROW_N   = 16;
    localparam int LED_COLOURS = 3;

    // The encoder works on a fixed wide vector so any COL_N up to OH_MAX can share it.
    localparam int OH_MAX   = 64;
    localparam int OH_IDX_W = 6;

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        SHIFT   = 2'd1,
        BLANK   = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [OH_IDX_W-1:0] idx;
        logic                valid;
    } onehot_res_t;

    // Index of the single set bit; valid is low (and idx 0) for zero or several bits set.
    function automatic onehot_res_t onehot_to_bin(input logic [OH_MAX-1:0] i_vec);
        onehot_res_t w_res;
        int          w_ones;
        w_res  = '0;
        w_ones = 0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (i_vec[i]) begin
                w_res.idx = OH_IDX_W'(i);
                w_ones++;
            end
        end
        w_res.valid = (w_ones == 1);
        if (!w_res.valid) begin
            w_res.idx = '0;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/led_matrix_rx_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall strobes for one link input.
// Strobes are withheld until the chain holds real pin samples after reset.
module link_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_valid,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_fill;
    logic              r_rise;
    logic              r_fall;

    // Strobe registers load on the same edge the new level appears at o_level,
    // so a strobe always describes the transition into the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_fill <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_fill <= {r_fill[STAGES-2:0], 1'b1};
            r_rise <= r_fill[STAGES-1] &  r_sync[STAGES-2] & ~r_sync[STAGES-1];
            r_fall <= r_fill[STAGES-1] & ~r_sync[STAGES-2] &  r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_valid = r_fill[STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/led_matrix_rx.sv
// Far-end receiver of the sclk/sdo/lat/colEn LED matrix link: deserialises each
// column's row bits, captures them at the latch and reports them with the column index.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   UNARMED | after reset; edges ignored until lat is seen low
//   SHIFT   | shifting sdo on sclk rises; lat rise captures the word
//   BLANK   | lat high; sclk ignored; lat fall publishes the captured word
module led_matrix_rx
    import led_matrix_rx_pkg::*;
#(
    parameter int COL_N       = LED_COL_N,
    parameter int ROW_N       = LED_ROW_N,
    parameter int COLOURS     = LED_COLOURS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       sdo,
    input  logic                       lat,
    input  logic [COL_N-1:0]           colEn,
    output logic [ROW_N*COLOURS-1:0]   row_data,
    output logic [$clog2(COL_N)-1:0]   row_col,
    output logic                       row_valid,
    output logic                       row_err,
    output logic                       col_err,
    output logic                       frame_start,
    output logic                       blank
);

    localparam int SERIAL_W = ROW_N * COLOURS;
    localparam int COL_W    = $clog2(COL_N);
    localparam int CNT_W    = $clog2(SERIAL_W + 2);

    logic w_sclk_level;
    logic w_sclk_valid;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_lat_level;
    logic w_lat_valid;
    logic w_lat_rise;
    logic w_lat_fall;
    logic w_unused_sclk;

    link_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (sclk),
        .o_level (w_sclk_level),
        .o_valid (w_sclk_valid),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    link_sync_edge #(.STAGES(SYNC_STAGES)) u_lat_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (lat),
        .o_level (w_lat_level),
        .o_valid (w_lat_valid),
        .o_rise  (w_lat_rise),
        .o_fall  (w_lat_fall)
    );

    assign w_unused_sclk = w_sclk_level ^ w_sclk_fall;

    logic [SYNC_STAGES-1:0] r_sdo_sync;
    logic [COL_N-1:0]       r_col_sync [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdo_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_col_sync[i] <= '0;
            end
        end else begin
            r_sdo_sync    <= {r_sdo_sync[SYNC_STAGES-2:0], sdo};
            r_col_sync[0] <= colEn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_col_sync[i] <= r_col_sync[i-1];
            end
        end
    end

    rx_state_t            r_state;
    logic [SERIAL_W-1:0]  r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [SERIAL_W-1:0]  r_pend;
    logic                 r_pend_bad;
    logic                 r_take;
    logic [SERIAL_W-1:0]  r_row_data;
    logic [COL_W-1:0]     r_row_col;
    logic                 r_row_valid;
    logic                 r_row_err;
    logic                 r_col_err;
    logic                 r_frame_start;

    logic                 w_shift_en;
    logic [SERIAL_W-1:0]  w_shift_next;
    logic [CNT_W-1:0]     w_cnt_next;
    onehot_res_t          w_oh;

    // Bit shift is resolved before the latch so a coincident sclk/lat rise keeps the bit.
    assign w_shift_en = (r_state == SHIFT) && w_sclk_rise && w_sclk_valid;

    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_bit_cnt;
        if (w_shift_en) begin
            w_shift_next = {r_shift[SERIAL_W-2:0], r_sdo_sync[SYNC_STAGES-1]};
            if (r_bit_cnt != CNT_W'(SERIAL_W + 1)) begin
                w_cnt_next = r_bit_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_oh = onehot_to_bin(OH_MAX'(r_col_sync[SYNC_STAGES-1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= UNARMED;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pend        <= '0;
            r_pend_bad    <= 1'b0;
            r_take        <= 1'b0;
            r_row_data    <= '0;
            r_row_col     <= '0;
            r_row_valid   <= 1'b0;
            r_row_err     <= 1'b0;
            r_col_err     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_take        <= 1'b0;
            r_row_valid   <= 1'b0;
            r_row_err     <= 1'b0;
            r_col_err     <= 1'b0;
            r_frame_start <= 1'b0;

            case (r_state)
                UNARMED: begin
                    if (w_lat_valid && !w_lat_level) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= w_cnt_next;
                    if (w_lat_rise) begin
                        r_pend     <= w_shift_next;
                        r_pend_bad <= (w_cnt_next != CNT_W'(SERIAL_W));
                        r_bit_cnt  <= '0;
                        r_state    <= BLANK;
                    end
                end
                BLANK: begin
                    if (w_lat_fall) begin
                        r_take  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                default: r_state <= UNARMED;
            endcase

            // Publish one cycle after the lat fall is seen, column sampled here.
            if (r_take) begin
                r_row_data    <= r_pend;
                r_row_err     <= r_pend_bad;
                r_row_col     <= COL_W'(w_oh.idx);
                r_col_err     <= !w_oh.valid;
                r_row_valid   <= 1'b1;
                r_frame_start <= w_oh.valid && (w_oh.idx == OH_IDX_W'(COL_N - 1));
            end
        end
    end

    assign row_data    = r_row_data;
    assign row_col     = r_row_col;
    assign row_valid   = r_row_valid;
    assign row_err     = r_row_err;
    assign col_err     = r_col_err;
    assign frame_start = r_frame_start;
    assign blank       = w_lat_level;

endmodule

// File: tb/tb_led_matrix_rx.sv
// Bench for led_matrix_rx: drives the link pins directly and predicts each latched
// row word from the bit history, bit count and column enable.
module tb_led_matrix_rx;

    localparam int S  = 2;
    localparam int SW = 48;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk  = 1'b0;
    logic        sdo   = 1'b0;
    logic        lat   = 1'b0;
    logic [15:0] colEn = 16'h0000;
    logic [47:0] row_data;
    logic [3:0]  row_col;
    logic        row_valid;
    logic        row_err;
    logic        col_err;
    logic        frame_start;
    logic        blank;

    always #5 clk = ~clk;

    led_matrix_rx #(.COL_N(16), .ROW_N(16), .COLOURS(3), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .sdo         (sdo),
        .lat         (lat),
        .colEn       (colEn),
        .row_data    (row_data),
        .row_col     (row_col),
        .row_valid   (row_valid),
        .row_err     (row_err),
        .col_err     (col_err),
        .frame_start (frame_start),
        .blank       (blank)
    );

    typedef struct {
        logic [47:0] data;
        logic [3:0]  col;
        logic        rerr;
        logic        cerr;
        logic        frame;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    bit          bits_q[$];
    int          m_cnt = 0;
    bit          m_armed = 0;
    bit          m_pend_ok = 0;
    exp_t        m_pend;
    exp_t        e_cmp;
    logic [47:0] m_last_data = '0;
    logic [3:0]  m_last_col = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] last48();
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < SW; i++) begin
            if (i < bits_q.size()) r[i] = bits_q[bits_q.size()-1-i];
        end
        return r;
    endfunction

    function automatic void col_model(input logic [15:0] c, output logic [3:0] idx, output logic err);
        err = ($countones(c) != 1);
        idx = '0;
        if (!err) begin
            for (int i = 0; i < 16; i++) if (c[i]) idx = 4'(i);
        end
    endfunction

    // Compare process: every published word against the model, idle cycles against held values.
    always @(negedge clk) begin
        if (rst_n) begin
            if (row_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_expect", {63'd0, row_valid}, 64'd0);
                end else begin
                    e_cmp = exp_q.pop_front();
                    check("row_data", {16'd0, row_data}, {16'd0, e_cmp.data});
                    check("row_col", {60'd0, row_col}, {60'd0, e_cmp.col});
                    check("row_err", {63'd0, row_err}, {63'd0, e_cmp.rerr});
                    check("col_err", {63'd0, col_err}, {63'd0, e_cmp.cerr});
                    check("frame_start", {63'd0, frame_start}, {63'd0, e_cmp.frame});
                    m_last_data = e_cmp.data;
                    m_last_col  = e_cmp.col;
                end
            end else begin
                check("hold", {9'd0, row_err, col_err, frame_start, row_col, row_data},
                      {12'd0, m_last_col, m_last_data});
            end
        end
    end

    task automatic send_bit(input bit b);
        sdo = b;
        @(negedge clk);
        sclk = 1'b1;
        if (m_armed) begin
            bits_q.push_back(b);
            m_cnt++;
        end
        repeat (2) @(negedge clk);
        sclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_vec(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic latch(input logic [15:0] col, input int toggles);
        colEn = col;
        @(negedge clk);
        lat = 1'b1;
        if (m_armed) begin
            m_pend.data = last48();
            m_pend.rerr = (m_cnt != SW);
            m_pend_ok   = 1;
        end
        m_cnt = 0;
        repeat (S - 1) @(negedge clk);
        check("blank_before_sync", {63'd0, blank}, 64'd0);
        @(negedge clk);
        check("blank_after_sync", {63'd0, blank}, 64'd1);
        repeat (4) @(negedge clk);
        repeat (toggles) begin
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (18) @(negedge clk);
        lat = 1'b0;
        if (m_pend_ok) begin
            col_model(col, m_pend.col, m_pend.cerr);
            m_pend.frame = !m_pend.cerr && (m_pend.col == 4'd15);
            exp_q.push_back(m_pend);
            m_pend_ok = 0;
        end
        m_armed = 1;
    endtask

    task automatic wait_valid(output int cyc, output logic [47:0] d, output logic [3:0] c,
                              output logic re, output logic ce, output logic fs);
        bit found;
        found = 0;
        cyc   = 0;
        while (!found && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (row_valid) found = 1;
        end
        if (!found) check("valid_timeout", {63'd0, row_valid}, 64'd1);
        d  = row_data;
        c  = row_col;
        re = row_err;
        ce = col_err;
        fs = frame_start;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          frames;
        logic [47:0] d;
        logic [3:0]  c;
        logic        re, ce, fs;

        repeat (3) @(negedge clk);
        check("reset_outputs", {7'd0, row_valid, row_err, col_err, frame_start, blank, row_col, row_data}, 64'd0);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        m_armed = 1;

        // Single leading one, last column of the frame.
        send_vec(64'h0000_8000_0000_0000, 48);
        latch(16'h8000, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t1_latency", 64'(cyc), 64'(S + 2));
        check("t1_data", {16'd0, d}, 64'h0000_8000_0000_0000);
        check("t1_col", {60'd0, c}, 64'd15);
        check("t1_frame", {63'd0, fs}, 64'd1);
        check("t1_errs", {62'd0, re, ce}, 64'd0);

        // Full column walk.
        frames = 0;
        for (int k = 15; k >= 0; k--) begin
            send_vec(64'h0000_A5A5_5A5A_0F0F, 48);
            latch(16'(1 << k), 0);
            wait_valid(cyc, d, c, re, ce, fs);
            check("t2_col", {60'd0, c}, 64'(k));
            check("t2_data", {16'd0, d}, 64'h0000_A5A5_5A5A_0F0F);
            if (fs) frames++;
        end
        check("t2_frames", 64'(frames), 64'd1);

        // Short and long bit counts.
        send_vec(64'h0000_1234_5678_9ABC, 47);
        latch(16'h0100, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t3_short_err", {63'd0, re}, 64'd1);
        check("t3_short_data", {16'd0, d}, 64'h0000_9234_5678_9ABC);
        send_vec(64'h0001_1234_5678_9ABC, 49);
        latch(16'h0200, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t3_long_err", {63'd0, re}, 64'd1);
        check("t3_long_data", {16'd0, d}, 64'h0000_1234_5678_9ABC);
        check("t3_long_col", {60'd0, c}, 64'd9);

        // Bad column enables.
        send_vec(64'h0000_FFFF_0000_FFFF, 48);
        latch(16'h0000, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t4_zero_colerr", {63'd0, ce}, 64'd1);
        check("t4_zero_col", {60'd0, c}, 64'd0);
        send_vec(64'h0000_FFFF_0000_FFFF, 48);
        latch(16'h0003, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t4_multi_colerr", {63'd0, ce}, 64'd1);
        check("t4_multi_col", {60'd0, c}, 64'd0);

        // sclk activity during blanking is ignored.
        send_vec(64'h0000_0F0F_F0F0_1111, 48);
        latch(16'h0040, 10);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t5_err", {63'd0, re}, 64'd0);
        check("t5_col", {60'd0, c}, 64'd6);
        send_vec(64'h0000_2222_4444_8888, 48);
        latch(16'h0020, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t5_next_err", {63'd0, re}, 64'd0);
        check("t5_next_data", {16'd0, d}, 64'h0000_2222_4444_8888);

        // Reset in the middle of a blank with lat still high after release.
        send_vec(64'h0000_5555_5555_5555, 48);
        colEn = 16'h0010;
        @(negedge clk);
        lat = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        bits_q.delete();
        m_cnt = 0;
        m_armed = 0;
        m_pend_ok = 0;
        m_last_data = '0;
        m_last_col = '0;
        #1 check("t6_reset_outputs", {7'd0, row_valid, row_err, col_err, frame_start, blank, row_col, row_data}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_blank_seen", {63'd0, blank}, 64'd1);
        lat = 1'b0;
        m_armed = 1;
        repeat (12) @(negedge clk);
        send_vec(64'h0000_0F0F_F0F0_A5A5, 48);
        latch(16'h0010, 0);
        wait_valid(cyc, d, c, re, ce, fs);
        check("t6_col", {60'd0, c}, 64'd4);
        check("t6_err", {63'd0, re}, 64'd0);
        check("t6_data", {16'd0, d}, 64'h0000_0F0F_F0F0_A5A5);

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
